// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the data-memory controller's state
// encoding and byte-enable constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2
    } dmem_state_t;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering for data-memory accesses: byte enables, replicated
// store data and sign-extended LDB load data.
module dmem_byte_lane
    import lc3b_types::*;
(
    input  logic        addr_lsb,
    input  logic        is_byte,
    input  logic [15:0] wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  byte_enable,
    output logic [15:0] lane_wdata,
    output logic [15:0] lane_rdata
);

    logic [7:0] sel_byte;

    always_comb begin
        byte_enable = BE_WORD;
        lane_wdata  = wdata;
        lane_rdata  = mem_rdata;
        sel_byte    = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
        if (is_byte) begin
            byte_enable = addr_lsb ? BE_HI : BE_LO;
            // The store byte goes on both lanes; the enable picks the target.
            lane_wdata  = {wdata[7:0], wdata[7:0]};
            lane_rdata  = {{8{sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: sequences direct and indirect loads and
// stores into one or two memory transactions and stalls until the last one.
module dmem_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] req_address,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_indirect,
    input  logic [15:0] req_wdata,
    output logic [15:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done
);

    // Handshake: a request is taken when valid_in and a strobe are seen in
    // IDLE; a memory strobe stays constant until the single-cycle mem_resp
    // that completes it, and done marks the cycle the MEM stage may advance.

    dmem_state_t state, next_state;

    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        is_write_q;
    logic        is_byte_q;
    logic        is_ind_q;

    logic        start;
    logic [1:0]  lane_be;
    logic [15:0] lane_wdata;
    logic [15:0] lane_rdata;

    assign start = (state == IDLE) && valid_in && (req_read || req_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            is_byte_q  <= 1'b0;
            is_ind_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (start) begin
                addr_q     <= req_address;
                wdata_q    <= req_wdata;
                // A request with both strobes set is treated as a load.
                is_write_q <= req_write && !req_read;
                is_byte_q  <= req_byte;
                is_ind_q   <= req_indirect;
            end else if (state == PTR && mem_resp) begin
                addr_q <= mem_rdata;
            end
        end
    end

    dmem_byte_lane u_lane (
        .addr_lsb    (addr_q[0]),
        .is_byte     (is_byte_q),
        .wdata       (wdata_q),
        .mem_rdata   (mem_rdata),
        .byte_enable (lane_be),
        .lane_wdata  (lane_wdata),
        .lane_rdata  (lane_rdata)
    );

    always_comb begin
        next_state      = state;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_wdata       = '0;
        done            = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next_state = req_indirect ? PTR : ACCESS;
            end
            PTR: begin
                // Pointer fetch is always a full aligned word.
                mem_read        = is_ind_q;
                mem_address     = {addr_q[15:1], 1'b0};
                mem_byte_enable = BE_WORD;
                if (mem_resp) next_state = ACCESS;
            end
            ACCESS: begin
                mem_read        = !is_write_q;
                mem_write       = is_write_q;
                mem_address     = {addr_q[15:1], 1'b0};
                mem_byte_enable = lane_be;
                mem_wdata       = lane_wdata;
                if (mem_resp) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign rdata = (done && !is_write_q) ? lane_rdata : 16'h0000;
    assign stall = start || ((state != IDLE) && !done);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomised bench for dmem_ctrl: a transaction-level model predicts every
// cycle of each request, and directed cases pin the model with literals.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] req_address;
    logic        req_read;
    logic        req_write;
    logic        req_byte;
    logic        req_indirect;
    logic [15:0] req_wdata;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] rdata;
    logic        stall;
    logic        done;

    dmem_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .req_address     (req_address),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_byte        (req_byte),
        .req_indirect    (req_indirect),
        .req_wdata       (req_wdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .rdata           (rdata),
        .stall           (stall),
        .done            (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected outputs for the current cycle, set by the driver
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_rd, exp_wr;
    logic [15:0] exp_rdata, exp_addr, exp_wdata;
    logic [1:0]  exp_be;

    // memory model, word-addressed by aligned byte address
    logic [15:0] mem [int];

    function automatic logic [15:0] mrd(input logic [15:0] a);
        int k;
        k = int'({a[15:1], 1'b0});
        return mem.exists(k) ? mem[k] : 16'h0000;
    endfunction

    // observations for literal checks
    int          obs_stall_cnt, obs_done_cnt, obs_n;
    logic [15:0] obs_rdata;
    logic [15:0] obs_addr [2];
    logic [15:0] obs_wdata [2];
    logic [1:0]  obs_be [2];
    logic        obs_rd [2];
    logic        obs_wr [2];

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 16'(stall), 16'(exp_stall));
            chk("done", 16'(done), 16'(exp_done));
            chk("rdata", rdata, exp_rdata);
            chk("mem_read", 16'(mem_read), 16'(exp_rd));
            chk("mem_write", 16'(mem_write), 16'(exp_wr));
            if (exp_rd || exp_wr) begin
                chk("mem_address", mem_address, exp_addr);
                chk("mem_byte_enable", 16'(mem_byte_enable), 16'(exp_be));
            end
            if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
        end
    end

    // inputs are set at posedge+1; present memory data, sample, advance
    task automatic tick();
        mem_rdata = (mem_read || mem_write) ? mrd(mem_address) : 16'($urandom);
        @(negedge clk);
        if (stall) obs_stall_cnt++;
        if (done) begin
            obs_done_cnt++;
            obs_rdata = rdata;
        end
        if (mem_resp && (mem_read || mem_write) && obs_n < 2) begin
            obs_addr[obs_n]  = mem_address;
            obs_wdata[obs_n] = mem_wdata;
            obs_be[obs_n]    = mem_byte_enable;
            obs_rd[obs_n]    = mem_read;
            obs_wr[obs_n]    = mem_write;
            obs_n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_done = 1'b0; exp_rdata = 16'h0;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_addr = 16'h0; exp_be = 2'b00; exp_wdata = 16'h0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in     = 1'($urandom_range(0, 1));
            req_read     = 1'b0;
            req_write    = 1'b0;
            req_address  = 16'($urandom);
            req_indirect = 1'($urandom_range(0, 1));
            mem_resp     = 1'($urandom_range(0, 1));
            set_idle_exp();
            tick();
        end
    endtask

    task automatic run_req(input logic [15:0] addr, input logic rd, input logic wr,
                           input logic byt, input logic ind, input logic [15:0] wdata,
                           input int l1, input int l2);
        logic        is_wr;
        logic [15:0] acc_addr, word, load_val, wd;
        logic [7:0]  lane;
        logic [1:0]  be;
        int          nph, lat;
        is_wr    = wr && !rd;
        nph      = ind ? 2 : 1;
        acc_addr = ind ? mrd(addr) : addr;
        be       = byt ? (acc_addr[0] ? 2'b10 : 2'b01) : 2'b11;
        wd       = byt ? {wdata[7:0], wdata[7:0]} : wdata;
        word     = mrd(acc_addr);
        lane     = acc_addr[0] ? word[15:8] : word[7:0];
        load_val = byt ? {{8{lane[7]}}, lane} : word;
        obs_stall_cnt = 0; obs_done_cnt = 0; obs_n = 0; obs_rdata = 16'h0;

        valid_in = 1'b1; req_address = addr; req_read = rd; req_write = wr;
        req_byte = byt; req_indirect = ind; req_wdata = wdata;
        mem_resp = 1'($urandom_range(0, 1));
        set_idle_exp();
        exp_stall = 1'b1;
        tick();

        for (int p = 0; p < nph; p++) begin
            lat = (p == 0) ? l1 : l2;
            for (int k = 0; k <= lat; k++) begin
                valid_in    = 1'($urandom_range(0, 1));
                req_address = 16'($urandom); req_read = 1'($urandom_range(0, 1));
                req_write   = 1'($urandom_range(0, 1)); req_byte = 1'($urandom_range(0, 1));
                req_indirect = 1'($urandom_range(0, 1)); req_wdata = 16'($urandom);
                mem_resp    = (k == lat);
                if (ind && p == 0) begin
                    exp_rd = 1'b1; exp_wr = 1'b0;
                    exp_addr = {addr[15:1], 1'b0}; exp_be = 2'b11;
                end else begin
                    exp_rd = !is_wr; exp_wr = is_wr;
                    exp_addr = {acc_addr[15:1], 1'b0}; exp_be = be;
                end
                exp_wdata = wd;
                exp_done  = (p == nph - 1) && (k == lat);
                exp_stall = !exp_done;
                exp_rdata = (exp_done && !is_wr) ? load_val : 16'h0;
                tick();
            end
        end

        if (is_wr) begin
            word = mrd(acc_addr);
            if (be[0]) word[7:0] = wd[7:0];
            if (be[1]) word[15:8] = wd[15:8];
            mem[int'({acc_addr[15:1], 1'b0})] = word;
        end
        valid_in = 1'b0;
        req_read = 1'b0;
        req_write = 1'b0;
        set_idle_exp();
    endtask

    // main sequence
    initial begin
        reset = 1'b1; valid_in = 1'b0; req_address = 16'h0; req_read = 1'b0;
        req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0; req_wdata = 16'h0;
        mem_rdata = 16'h0; mem_resp = 1'b0;
        set_idle_exp();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mem_read", 16'(mem_read), 16'h0);
        chk("rst_mem_write", 16'(mem_write), 16'h0);
        chk("rst_be", 16'(mem_byte_enable), 16'h0);
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_mem_address", mem_address, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        mem[int'(16'h3000)] = 16'hBEEF;
        mem[int'(16'h4002)] = 16'h80FF;
        mem[int'(16'h5000)] = 16'h6002;
        mem[int'(16'h6002)] = 16'h00AA;
        mem[int'(16'h7100)] = 16'h7000;

        run_req(16'h3001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2, 0);
        chk("ldr_rdata", obs_rdata, 16'hBEEF);
        chk("ldr_addr", obs_addr[0], 16'h3000);
        chk("ldr_be", 16'(obs_be[0]), 16'h3);
        chk("ldr_stall_cycles", 16'(obs_stall_cnt), 16'd3);

        run_req(16'h4003, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 0, 0);
        chk("ldb_be", 16'(obs_be[0]), 16'h2);
        chk("ldb_rdata", obs_rdata, 16'hFF80);
        chk("ldb_stall_cycles", 16'(obs_stall_cnt), 16'd1);

        run_req(16'h4002, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 2, 0);
        chk("stb_write", 16'(obs_wr[0]), 16'h1);
        chk("stb_be", 16'(obs_be[0]), 16'h1);
        chk("stb_wdata", obs_wdata[0], 16'h3434);
        chk("stb_stall_cycles", 16'(obs_stall_cnt), 16'd3);

        run_req(16'h5000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1, 2);
        chk("ldi_ptr_addr", obs_addr[0], 16'h5000);
        chk("ldi_acc_addr", obs_addr[1], 16'h6002);
        chk("ldi_rdata", obs_rdata, 16'h00AA);
        chk("ldi_done_count", 16'(obs_done_cnt), 16'd1);
        chk("ldi_stall_cycles", 16'(obs_stall_cnt), 16'd5);

        run_req(16'h7100, 1'b0, 1'b1, 1'b0, 1'b1, 16'hCAFE, 0, 1);
        chk("sti_ptr_read", 16'(obs_rd[0]), 16'h1);
        chk("sti_ptr_addr", obs_addr[0], 16'h7100);
        chk("sti_acc_write", 16'(obs_wr[1]), 16'h1);
        chk("sti_acc_addr", obs_addr[1], 16'h7000);
        chk("sti_wdata", obs_wdata[1], 16'hCAFE);
        chk("sti_be", 16'(obs_be[1]), 16'h3);

        // reset while the pointer fetch is outstanding
        obs_done_cnt = 0;
        valid_in = 1'b1; req_address = 16'h5000; req_read = 1'b1; req_write = 1'b0;
        req_byte = 1'b0; req_indirect = 1'b1; mem_resp = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
        tick();
        valid_in = 1'b0; req_read = 1'b0;
        set_idle_exp();
        exp_stall = 1'b1; exp_rd = 1'b1; exp_addr = 16'h5000; exp_be = 2'b11;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_resp = 1'b1;
        set_idle_exp();
        tick();
        mem_resp = 1'b0;
        tick();
        chk("rst_mid_done_count", 16'(obs_done_cnt), 16'd0);
        run_req(16'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1, 0);
        chk("post_rst_rdata", obs_rdata, 16'hBEEF);

        // randomized traffic in a small region so pointers and data collide
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) mem[int'(16'h8000) + 2 * i] = 16'h8000 + 16'($urandom_range(0, 63));
            else mem[int'(16'h8000) + 2 * i] = 16'($urandom);
        end
        for (int i = 0; i < 200; i++) begin
            int op;
            logic r, w;
            op = $urandom_range(0, 3);
            r  = (op == 0) || (op == 2) || (op == 3);
            w  = (op == 1) || (op == 2);
            run_req(16'h8000 + 16'($urandom_range(0, 63)), r, w, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), 16'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the pipeline's MEM stage and the data-memory port. It turns one MEM-stage request (word/byte, load/store, direct/indirect) into one or two memory transactions. It handles byte-lane steering and LDB sign-extension, and holds `stall` high until the final `mem_resp`. LDI/STI indirection is sequenced here, so the MEM stage only presents a request and waits.

## Interface
Parameters: none. Widths come from `lc3b_types` (`lc3b_word` = 16 bits).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: MEM-stage instruction is valid.
- `req_address` in 16: effective address.
- `req_read` in 1: load request.
- `req_write` in 1: store request.
- `req_byte` in 1: byte access (LDB/STB).
- `req_indirect` in 1: LDI/STI; `req_address` points to the pointer word.
- `req_wdata` in 16: store data; byte stores use `[7:0]`.
- `mem_address` out 16: memory address.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_byte_enable` out 2: bit 1 = high byte, bit 0 = low byte.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_resp` in 1: memory completion; 1-cycle pulse.
- `rdata` out 16: load result to the MEM stage.
- `stall` out 1: freeze the pipeline.
- `done` out 1: final access completes this cycle.

## Operation
- `start` = `valid_in & (req_read | req_write)` while in IDLE. If both strobes are set, the request is a read.
- On `start`, register:
  - `addr_q` = `req_address`
  - `wdata_q` = `req_wdata`
  - `is_write_q`, `is_byte_q`, `is_ind_q`
- FSM states:
  - IDLE: no strobes. On `start`, go to PTR if `req_indirect`, else ACCESS.
  - PTR:
    - Drive `mem_read=1`, `mem_address={addr_q[15:1],1'b0}`, `mem_byte_enable=2'b11`.
    - On `mem_resp`: `addr_q <= mem_rdata`, go to ACCESS.
  - ACCESS:
    - Drive `mem_read = !is_write_q`, `mem_write = is_write_q`.
    - On `mem_resp`: go to IDLE, `done=1`.
- Address and lane rules in ACCESS:
  - Word: `mem_address={addr_q[15:1],0}`, `mem_byte_enable=2'b11`, `mem_wdata=wdata_q`.
  - Byte: `mem_address={addr_q[15:1],0}`, `mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01`, `mem_wdata={wdata_q[7:0],wdata_q[7:0]}`.
- `rdata`, combinational from `mem_rdata`, valid only when `done`:
  - Word: `mem_rdata`.
  - Byte: sign-extended lane, `addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]`.
  - `rdata=0` when `done=0` or the access is a store.
- `stall` = `start` (in IDLE) `| (state!=IDLE & !done)`.
- `mem_resp` in IDLE is ignored.
- `req_*` changes after `start` are ignored; only registered copies are used.

## Timing
- Reset values: state IDLE; `mem_read`, `mem_write`, `mem_byte_enable`, `stall`, `done`, `rdata` all 0; `mem_address`, `mem_wdata` 0.
- Strobes are held constant until `mem_resp`.
- Direct access with memory latency L (≥0 cycles from strobe to `mem_resp`): `stall` high for L+1 cycles. It drops in the `mem_resp` cycle, where `done=1`.
- Indirect access: `stall` high for L1+L2+2 cycles.
- The MEM stage advances on the `done` cycle. The next cycle is IDLE with a new request, and back-to-back requests are accepted.
- `reset` mid-transaction:
  - Return to IDLE next edge; strobes drop.
  - A `mem_resp` arriving later for the abandoned access is ignored.

## Structure
- Add to `lc3b_types`:
  - `dmem_state_t` enum {IDLE, PTR, ACCESS}.
  - Constants `BE_WORD=2'b11`, `BE_LO=2'b01`, `BE_HI=2'b10`.
- One combinational sub-module, `dmem_byte_lane`:
  - Inputs: `addr[0]`, byte flag, `wdata`, `mem_rdata`.
  - Outputs: `byte_enable`, steered `wdata`, extended `rdata`.
- The FSM and request registers stay in `dmem_ctrl`.

## Test plan
- Word LDR:
  - Stimulus: `req_address=0x3001`, read, mem returns `0xBEEF` with L=2.
  - Required: `mem_address=0x3000`, `be=11`, `stall` high 3 cycles, `done` with `rdata=0xBEEF`.
- LDB high byte:
  - Stimulus: addr `0x4003`, mem returns `0x80FF` with L=0.
  - Required: `be=10`, `rdata=0xFF80`, `stall` high exactly 1 cycle.
- STB low byte:
  - Stimulus: addr `0x4002`, `wdata=0x1234`.
  - Required: `mem_write=1`, `be=01`, `mem_wdata=0x3434`, strobe held until `mem_resp`.
- LDI:
  - Stimulus: addr `0x5000`, memory holds `[0x5000]=0x6002` and `[0x6002]=0x00AA`.
  - Required: read `0x5000`, then read `0x6002`, `rdata=0x00AA`, `done` once.
- STI:
  - Stimulus: pointer `0x7000`, `wdata=0xCAFE`.
  - Required: read pointer, then write `0xCAFE` to `0x7000` with `be=11`.
- Reset during PTR with `mem_resp` pending:
  - Required: IDLE next cycle, strobes 0.
  - A late `mem_resp` produces no `done` and no state change.
